// File: rtl/keypad_pkg.sv
// ============================================================================
// Module      : keypad_pkg
// Description : Shared keypad constants and types for the debouncer and encoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package keypad_pkg;

    localparam int NUM_KEYS             = 14;
    localparam int SAMPLE_DIV_DEFAULT   = 100000;
    localparam int STABLE_COUNT_DEFAULT = 4;
    localparam int KEY_MODE_IDX         = 13;

    typedef logic [NUM_KEYS-1:0] keyvec_t;

endpackage

`default_nettype wire

// File: rtl/debounce_cell.sv
// ============================================================================
// Module      : debounce_cell
// Description : Two-flop synchroniser plus tick-driven bounce filter for one key.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_cell #(
    parameter int STABLE_COUNT = 4
) (
    input  logic clk,
    input  logic n_rst,
    input  logic raw_i,
    input  logic tick_i,
    output logic level_o,
    output logic rise_o
);

    localparam int c_cnt_w = $clog2(STABLE_COUNT + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(STABLE_COUNT - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_differ;
    logic               w_accept;

    assign w_differ = r_sync2 ^ r_level;
    assign w_accept = tick_i & w_differ & (r_cnt == c_cnt_last);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= raw_i;
            r_sync2 <= r_sync1;
            // Any agreeing tick restarts the run of disagreeing samples.
            if (tick_i) begin
                if (!w_differ) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_cnt_last) begin
                    r_level <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign level_o = r_level;
    // Combinational: asserted in the cycle before level_o goes 0->1.
    assign rise_o  = w_accept & r_sync2;

endmodule

`default_nettype wire

// File: rtl/keypad_debouncer.sv
// ============================================================================
// Module      : keypad_debouncer
// Description : Debounces the raw keypad pins and flags key presses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_debouncer #(
    parameter int NUM_KEYS     = keypad_pkg::NUM_KEYS,
    parameter int SAMPLE_DIV   = keypad_pkg::SAMPLE_DIV_DEFAULT,
    parameter int STABLE_COUNT = keypad_pkg::STABLE_COUNT_DEFAULT
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic [NUM_KEYS-1:0] keypad_raw_i,
    output logic [NUM_KEYS-1:0] keypad_o,
    output logic                press_o,
    output logic                sample_tick_o
);

    import keypad_pkg::*;

    localparam int c_div_w = $clog2(SAMPLE_DIV);
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(SAMPLE_DIV - 1);

    logic [c_div_w-1:0]  r_div;
    logic                r_tick;
    logic                r_press;
    logic [NUM_KEYS-1:0] w_level;
    logic [NUM_KEYS-1:0] w_rise;

    // Tick is registered, so it first appears SAMPLE_DIV cycles after reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_div  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= (r_div == c_div_last);
            if (r_div == c_div_last) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_cell
            debounce_cell #(
                .STABLE_COUNT (STABLE_COUNT)
            ) u_cell (
                .clk     (clk),
                .n_rst   (n_rst),
                .raw_i   (keypad_raw_i[gi]),
                .tick_i  (r_tick),
                .level_o (w_level[gi]),
                .rise_o  (w_rise[gi])
            );
        end
    endgenerate

    // One pulse per update, however many keys rise together.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_press <= 1'b0;
        end else begin
            r_press <= |w_rise;
        end
    end

    assign keypad_o      = w_level;
    assign press_o       = r_press;
    assign sample_tick_o = r_tick;

endmodule

`default_nettype wire

// File: tb/tb_keypad_debouncer.sv
// ============================================================================
// Module      : tb_keypad_debouncer
// Description : Scoreboard bench for keypad_debouncer (SAMPLE_DIV=4, STABLE_COUNT=3).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_keypad_debouncer;

    localparam int c_div  = 4;
    localparam int c_stab = 3;
    localparam int c_lat_min = 2 + (c_stab - 1) * c_div + 1;
    localparam int c_lat_max = 2 + c_stab * c_div;

    typedef struct packed {
        logic [13:0] level;
        logic        press;
    } exp_t;

    logic        clk;
    logic        n_rst;
    logic [13:0] keypad_raw_i;
    logic [13:0] keypad_o;
    logic        press_o;
    logic        sample_tick_o;

    exp_t exp_q[$];
    int   n_vec;
    int   n_err;

    keypad_debouncer #(
        .NUM_KEYS     (14),
        .SAMPLE_DIV   (c_div),
        .STABLE_COUNT (c_stab)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .keypad_raw_i  (keypad_raw_i),
        .keypad_o      (keypad_o),
        .press_o       (press_o),
        .sample_tick_o (sample_tick_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for keypad_o to move; reports latency and whether press_o fired early.
    task automatic wait_change(input int budget, output int cycles,
                               output bit changed, output bit early_press);
        logic [13:0] prev;
        prev        = keypad_o;
        cycles      = 0;
        changed     = 1'b0;
        early_press = 1'b0;
        while (cycles < budget && !changed) begin
            step();
            cycles++;
            if (keypad_o !== prev) changed = 1'b1;
            else if (press_o !== 1'b0) early_press = 1'b1;
        end
    endtask

    task automatic test_reset();
        int bad_tick = 0, bad_out = 0;
        n_rst = 1'b0;
        keypad_raw_i = '0;
        repeat (3) step();
        n_vec++;
        if (keypad_o !== 14'h0 || press_o !== 1'b0 || sample_tick_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: keypad_o=%h press=%b tick=%b, want 0/0/0",
                     keypad_o, press_o, sample_tick_o);
        end
        n_rst = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (sample_tick_o !== ((c % c_div) == 0)) bad_tick++;
            if (keypad_o !== 14'h0 || press_o !== 1'b0) bad_out++;
        end
        n_vec++;
        if (bad_tick != 0) begin
            n_err++;
            $display("FAIL tick_period: %0d cycles with wrong tick, want 0", bad_tick);
        end
        n_vec++;
        if (bad_out != 0) begin
            n_err++;
            $display("FAIL idle_outputs: %0d cycles with nonzero output, want 0", bad_out);
        end
    endtask

    // Drives a new raw vector, expects one scoreboard entry to emerge.
    task automatic apply_and_check(input string name, input logic [13:0] raw,
                                   input logic [13:0] lvl, input logic pr);
        int    cyc;
        bit    chg, early;
        exp_t  e;
        keypad_raw_i = raw;
        exp_q.push_back('{level: lvl, press: pr});
        wait_change(40, cyc, chg, early);
        n_vec++;
        if (!chg) begin
            n_err++;
            $display("FAIL %s_timeout: keypad_o stuck at %h after %0d cycles", name, keypad_o, cyc);
            void'(exp_q.pop_front());
            return;
        end
        e = exp_q.pop_front();
        if (keypad_o !== e.level) begin
            n_err++;
            $display("FAIL %s_level: keypad_o=%h, want %h", name, keypad_o, e.level);
        end
        n_vec++;
        if (press_o !== e.press) begin
            n_err++;
            $display("FAIL %s_press: press_o=%b, want %b", name, press_o, e.press);
        end
        n_vec++;
        if (cyc < c_lat_min || cyc > c_lat_max) begin
            n_err++;
            $display("FAIL %s_latency: %0d cycles, want %0d..%0d", name, cyc, c_lat_min, c_lat_max);
        end
        n_vec++;
        if (early) begin
            n_err++;
            $display("FAIL %s_early_press: press_o=1 before update, want 0", name);
        end
        step();
        n_vec++;
        if (press_o !== 1'b0) begin
            n_err++;
            $display("FAIL %s_press_width: press_o=%b one cycle later, want 0", name, press_o);
        end
    endtask

    task automatic test_single_press();
        apply_and_check("press0", 14'h0001, 14'h0001, 1'b1);
    endtask

    task automatic test_release();
        apply_and_check("release0", 14'h0000, 14'h0000, 1'b0);
    endtask

    task automatic test_bounce();
        int bad_lvl = 0, bad_pr = 0;
        int seg_len[4] = '{8, 4, 8, 24};
        logic seg_val[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int s = 0; s < 4; s++) begin
            keypad_raw_i[5] = seg_val[s];
            for (int c = 0; c < seg_len[s]; c++) begin
                step();
                if (keypad_o !== 14'h0) bad_lvl++;
                if (press_o !== 1'b0) bad_pr++;
            end
        end
        n_vec++;
        if (bad_lvl != 0) begin
            n_err++;
            $display("FAIL bounce_level: %0d cycles with keypad_o!=0, want 0", bad_lvl);
        end
        n_vec++;
        if (bad_pr != 0) begin
            n_err++;
            $display("FAIL bounce_press: %0d cycles with press_o=1, want 0", bad_pr);
        end
    endtask

    task automatic test_multi_key();
        apply_and_check("multi", 14'h2008, 14'h2008, 1'b1);
        apply_and_check("multi_rel", 14'h0000, 14'h0000, 1'b0);
    endtask

    task automatic test_reset_mid_count();
        int   seen, cyc;
        bit   chg, early;
        exp_t e;
        apply_and_check("mode", 14'h2000, 14'h2000, 1'b1);
        keypad_raw_i = 14'h2001;
        repeat (2) step();
        seen = 0;
        for (int c = 0; c < 20 && seen < 2; c++) begin
            if (sample_tick_o === 1'b1) seen++;
            if (seen < 2) step();
        end
        step();
        #2;
        n_rst = 1'b0;
        #1;
        n_vec++;
        if (keypad_o !== 14'h0 || press_o !== 1'b0 || sample_tick_o !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: keypad_o=%h press=%b tick=%b, want 0/0/0",
                     keypad_o, press_o, sample_tick_o);
        end
        repeat (2) step();
        n_rst = 1'b1;
        exp_q.push_back('{level: 14'h2001, press: 1'b1});
        wait_change(40, cyc, chg, early);
        n_vec++;
        if (!chg) begin
            n_err++;
            $display("FAIL rst_reaccept_timeout: keypad_o stuck at %h", keypad_o);
            void'(exp_q.pop_front());
            return;
        end
        e = exp_q.pop_front();
        if (keypad_o !== e.level || press_o !== e.press) begin
            n_err++;
            $display("FAIL rst_reaccept: keypad_o=%h press=%b, want %h/%b",
                     keypad_o, press_o, e.level, e.press);
        end
        // Prescaler restarts, so ticks evaluate at edges 5, 9, 13 after release.
        n_vec++;
        if (cyc != 13) begin
            n_err++;
            $display("FAIL rst_reaccept_latency: %0d cycles, want 13", cyc);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        n_rst = 1'b0;
        keypad_raw_i = '0;
        test_reset();
        test_single_press();
        test_release();
        test_bounce();
        test_multi_key();
        test_reset_mid_count();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
